uart_tx_piso_buffered: RTL and testbench
========================================

// Module: uart_tx_piso_buffered
// PURPOSE
//  Parametrised, double-buffered parallel-in/serial-out shifter for the UART TX path.
//  - Accepts a word into a holding register via a valid/ready handshake.
//  - Moves the word to the shift register when the TX FSM enables it on a baud tick.
//  - Shifts out 1..WIDTH bits, LSB- or MSB-first, then pulses ser_done.
//  - Computes even parity of the shifted word for the FSM's parity state.
// PARAMETERS
//  WIDTH      8     max data bits per word
//  CNT_W      4     bit-counter / data_len width, >= clog2(WIDTH+1)
//  IDLE_LEVEL 1'b1  ser_data level when not shifting
// PORTS
//  CLK         in   1      clock; all logic on posedge
//  RST         in   1      asynchronous, active-low reset
//  DATA        in   WIDTH  parallel word
//  DATA_VALID  in   1      DATA is presented
//  data_ready  out  1      holding register empty; accept = DATA_VALID & data_ready
//  word_avail  out  1      holding register full
//  ser_en      in   1      TX FSM requests/keeps shifting
//  bit_tick    in   1      baud strobe, 1-cycle pulse per bit period
//  msb_first   in   1      0: LSB first, 1: MSB first; latched at load
//  data_len    in   CNT_W  bits per word, 1..WIDTH; 0 or >WIDTH means WIDTH; latched at load
//  ser_data    out  1      serial bit, registered
//  ser_done    out  1      1-cycle pulse, last bit period complete
//  busy        out  1      shift in progress
//  parity_even out  1      XOR of the latched word's len LSBs; valid from load until next load
// BEHAVIOUR
//  - Reset: ser_data=IDLE_LEVEL, ser_done=0, busy=0, data_ready=1, word_avail=0,
//    parity_even=0, hold/shift registers=0, state=IDLE.
//  - Holding register:
//    - On accept: hold<=DATA, full<=1.
//    - data_ready=!full, registered; no accept in the cycle the word is loaded to the shifter.
//    - DATA_VALID while full: ignored; DATA need not be held stable.
//  - FSM states: IDLE, SHIFT.
//  - load = IDLE & ser_en & bit_tick & full. On load:
//    - full<=0, busy<=1, state<=SHIFT, bit_cnt<=0.
//    - latch len, msb_first and parity_even.
//    - ser_data<=first bit: DATA[0] if LSB-first, DATA[len-1] if MSB-first.
//    - MSB-first: word is pre-aligned so bit len-1 sits at the shift MSB.
//  - IDLE with ser_en=1 and full=0: stay IDLE; ser_data=IDLE_LEVEL.
//  - In SHIFT, on bit_tick:
//    - bit_cnt<len-1: ser_data<=next bit, bit_cnt+1.
//    - bit_cnt==len-1: ser_done<=1 for one cycle, busy<=0, ser_data<=IDLE_LEVEL, state<=IDLE.
//  - Timing: each bit is held exactly one tick period; latency load -> ser_done = len tick periods.
//  - Back-to-back: the earliest next load is the next bit_tick after ser_done, so there is
//    at least one bit gap, which the FSM fills with parity/stop bits.
//  - ser_en=0 in SHIFT (abort): next cycle IDLE, busy=0, ser_data=IDLE_LEVEL, no ser_done.
//    The shifted word is discarded; the holding register is unaffected.
//  - Accept during SHIFT is allowed: this is the double-buffer behaviour.
//  - bit_tick while IDLE and no load: no effect.
//  - Reset asserted mid-word: immediate return to reset values; no ser_done.
// STRUCTURE
//  - uart_pkg holds: state localparams (IDLE=1'b0, SHIFT=1'b1), the len-clamp function,
//    and the IDLE_LEVEL default.
//  - One sub-module, tx_hold_reg: holding register plus valid/ready logic.
//    Ports: CLK, RST, DATA, DATA_VALID, take -> hold_data, full, data_ready.
//  - Top level: FSM, bit counter, shift register, parity.
// TESTING
//  1. Reset mid-SHIFT -> ser_data=1, busy=0, data_ready=1, no ser_done pulse.
//  2. WIDTH=8, LSB-first, len=0 (treated as 8), DATA=8'hA5, tick every 16 clk
//     -> ser_data 1,0,1,0,0,1,0,1; ser_done 128 clk after load; parity_even=0.
//  3. MSB-first, len=5, DATA=8'hF3 -> ser_data 1,0,0,1,1; ser_done after 5 ticks; parity_even=1.
//  4. Double buffer: 8'h01 loaded, accept 8'hFF during SHIFT -> data_ready=0;
//     8'hFF loads on the first tick after ser_done.
//  5. ser_en dropped after 3 bits of 8'h0F -> IDLE next clk, no ser_done, holding register intact.
//  6. DATA_VALID with data_ready=0 while full (8'h55) -> 8'h55 retained; the new DATA is dropped.

Source files
------------

// File: rtl/uart_tx_piso_buffered_pkg.sv
// Shared types and helpers for the buffered UART TX parallel-in/serial-out shifter.
package uart_pkg;

    // Shifter FSM states; encoding is fixed so the state bit can be probed directly.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Line level driven on ser_data whenever no data bit is being shifted.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    // Map a requested word length onto 1..width; zero or oversize requests mean a full word.
    function automatic int clamp_len(input int len_in, input int width);
        if ((len_in == 0) || (len_in > width)) begin
            return width;
        end
        return len_in;
    endfunction

endpackage

// File: rtl/uart_tx_piso_buffered_tx_hold_reg.sv
// Holding register for the TX shifter: one-word buffer with a valid/ready input side.
module tx_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             DATA_VALID,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             full,
    output logic             data_ready
);

    logic accept;

    // data_ready is its own flop kept equal to !full, so it is glitch-free at the port.
    assign accept = DATA_VALID & data_ready;

    // Capture a word on accept and release the buffer when the shifter takes it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data  <= '0;
            full       <= 1'b0;
            data_ready <= 1'b1;
        end else if (accept) begin
            hold_data  <= DATA;
            full       <= 1'b1;
            data_ready <= 1'b0;
        end else if (take) begin
            full       <= 1'b0;
            data_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_piso_buffered.sv
// Double-buffered PISO shifter for the UART TX path: FSM, bit counter, shift register, parity.
module uart_tx_piso_buffered
    import uart_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   CNT_W      = 4,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             DATA_VALID,
    output logic             data_ready,
    output logic             word_avail,
    input  logic             ser_en,
    input  logic             bit_tick,
    input  logic             msb_first,
    input  logic [CNT_W-1:0] data_len,
    output logic             ser_data,
    output logic             ser_done,
    output logic             busy,
    output logic             parity_even
);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   hold_data;
    logic               full;
    logic               load;
    logic               step;
    logic               finish;
    logic               abort;
    logic [CNT_W-1:0]   len_now;
    logic [CNT_W-1:0]   len_reg;
    logic               msb_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   aligned;
    logic               par_now;
    int                 shamt;

    tx_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .take       (load),
        .hold_data  (hold_data),
        .full       (full),
        .data_ready (data_ready)
    );

    assign word_avail = full;

    // Effective length, MSB-first pre-alignment and parity of the word about to be loaded.
    always_comb begin
        len_now = CNT_W'(clamp_len(int'(data_len), WIDTH));
        shamt   = WIDTH - int'(len_now);
        aligned = hold_data << shamt;
        par_now = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(len_now)) begin
                par_now = par_now ^ hold_data[i];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort (ser_en low) wins over a coincident bit_tick.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ser_en && bit_tick && full) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (!ser_en) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (bit_tick) begin
                    if (bit_cnt == (len_reg - CNT_W'(1))) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: the first bit goes out at load, each further tick presents the next one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_data    <= IDLE_LEVEL;
            ser_done    <= 1'b0;
            busy        <= 1'b0;
            parity_even <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            len_reg     <= CNT_W'(WIDTH);
            msb_reg     <= 1'b0;
        end else begin
            ser_done <= 1'b0;
            if (load) begin
                busy        <= 1'b1;
                bit_cnt     <= '0;
                len_reg     <= len_now;
                msb_reg     <= msb_first;
                parity_even <= par_now;
                if (msb_first) begin
                    ser_data  <= aligned[WIDTH-1];
                    shift_reg <= aligned << 1;
                end else begin
                    ser_data  <= hold_data[0];
                    shift_reg <= hold_data >> 1;
                end
            end else if (step) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (msb_reg) begin
                    ser_data  <= shift_reg[WIDTH-1];
                    shift_reg <= shift_reg << 1;
                end else begin
                    ser_data  <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                end
            end else if (finish) begin
                ser_done <= 1'b1;
                busy     <= 1'b0;
                ser_data <= IDLE_LEVEL;
            end else if (abort) begin
                busy     <= 1'b0;
                ser_data <= IDLE_LEVEL;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_piso_buffered.sv
// Scoreboard bench for uart_tx_piso_buffered: directed words, monitor reassembles serial output.
module tb_uart_tx_piso_buffered;

    typedef struct {
        logic [7:0] bits;
        int         nbits;
        logic       parity;
        logic       aborted;
        int         latency;
        int         gap;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       data_ready;
    logic       word_avail;
    logic       ser_en;
    logic       bit_tick;
    logic       msb_first;
    logic [3:0] data_len;
    logic       ser_data;
    logic       ser_done;
    logic       busy;
    logic       parity_even;

    int   vectors = 0;
    int   errors  = 0;
    exp_t exp_q[$];
    exp_t cur_exp;

    logic       in_word   = 1'b0;
    logic [7:0] got       = '0;
    int         nb        = 0;
    logic       par_s     = 1'b0;
    int         cyc       = 0;
    int         t_load    = 0;
    int         last_done = 0;
    int         word_id   = 0;
    logic       tick_q    = 1'b0;

    uart_tx_piso_buffered dut (
        .CLK         (CLK),
        .RST         (RST),
        .DATA        (DATA),
        .DATA_VALID  (DATA_VALID),
        .data_ready  (data_ready),
        .word_avail  (word_avail),
        .ser_en      (ser_en),
        .bit_tick    (bit_tick),
        .msb_first   (msb_first),
        .data_len    (data_len),
        .ser_data    (ser_data),
        .ser_done    (ser_done),
        .busy        (busy),
        .parity_even (parity_even)
    );

    // 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Baud strobe: one-cycle pulse every 16 clocks, changed on the falling edge.
    initial begin
        bit_tick = 1'b0;
        forever begin
            repeat (15) @(negedge CLK);
            bit_tick = 1'b1;
            @(negedge CLK);
            bit_tick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present a word on the handshake and push what the line should carry for it.
    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] len, input logic msb,
                                 input logic [7:0] eb, input int en, input logic ep,
                                 input logic ea, input int elat, input int egap);
        exp_t e;
        int   n;
        e.bits = eb; e.nbits = en; e.parity = ep; e.aborted = ea; e.latency = elat; e.gap = egap;
        exp_q.push_back(e);
        @(negedge CLK);
        DATA       = d;
        DATA_VALID = 1'b1;
        data_len   = len;
        msb_first  = msb;
        n = 0;
        while (!data_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!data_ready) checkOutput("accept_timeout", data_ready, 1);
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    task automatic waitBusy(input logic level, input string what);
        int n;
        n = 0;
        while (busy !== level && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (busy !== level) checkOutput(what, busy, level);
    endtask

    task automatic waitWordEnd();
        waitBusy(1'b1, "load_timeout");
        waitBusy(1'b0, "done_timeout");
    endtask

    task automatic waitTicks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            while (!bit_tick) @(posedge CLK);
        end
    endtask

    // Monitor: rebuild each word from ser_data at tick edges and compare against the queue.
    always @(posedge CLK) begin
        cyc    = cyc + 1;
        tick_q = bit_tick;
        #1;
        if (busy && !in_word) begin
            in_word = 1'b1;
            nb      = 0;
            got     = '0;
            par_s   = parity_even;
            t_load  = cyc;
        end
        if (in_word && busy && tick_q) begin
            if (nb < 8) got[nb] = ser_data;
            nb++;
        end else if (in_word && !busy) begin
            in_word = 1'b0;
            if (exp_q.size() == 0) begin
                checkOutput("stray_word", exp_q.size(), 1);
            end else begin
                cur_exp = exp_q.pop_front();
                checkOutput($sformatf("word%0d_bits", word_id), got, cur_exp.bits);
                checkOutput($sformatf("word%0d_nbits", word_id), nb, cur_exp.nbits);
                checkOutput($sformatf("word%0d_parity", word_id), par_s, cur_exp.parity);
                checkOutput($sformatf("word%0d_ser_done", word_id), ser_done, !cur_exp.aborted);
                checkOutput($sformatf("word%0d_idle_level", word_id), ser_data, 1);
                if (cur_exp.latency >= 0)
                    checkOutput($sformatf("word%0d_latency", word_id), cyc - t_load, cur_exp.latency);
                if (cur_exp.gap >= 0)
                    checkOutput($sformatf("word%0d_gap", word_id), t_load - last_done, cur_exp.gap);
                word_id++;
            end
            last_done = cyc;
        end else if (!in_word && ser_done) begin
            checkOutput("stray_ser_done", ser_done, 0);
        end
    end

    // Safety net in case the sequence stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        RST        = 1'b1;
        DATA       = '0;
        DATA_VALID = 1'b0;
        ser_en     = 1'b0;
        msb_first  = 1'b0;
        data_len   = '0;
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_ser_data", ser_data, 1);
        checkOutput("rst_ser_done", ser_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_data_ready", data_ready, 1);
        checkOutput("rst_word_avail", word_avail, 0);
        checkOutput("rst_parity", parity_even, 0);
        @(negedge CLK);
        RST = 1'b1;

        // A5, LSB-first, len 0 -> 8 bits 1,0,1,0,0,1,0,1, 128 clocks, parity 0
        ser_en = 1'b1;
        applyStimulus(8'hA5, 4'd0, 1'b0, 8'hA5, 8, 1'b0, 1'b0, 128, -1);
        waitWordEnd();

        // F3, MSB-first, len 5 -> 1,0,0,1,1, 80 clocks, parity 1
        applyStimulus(8'hF3, 4'd5, 1'b1, 8'h19, 5, 1'b1, 1'b0, 80, -1);
        waitWordEnd();
        @(negedge CLK);
        checkOutput("parity_held_after_done", parity_even, 1);

        // Double buffer: FF accepted while 01 shifts, loads one tick after ser_done
        applyStimulus(8'h01, 4'd8, 1'b0, 8'h01, 8, 1'b1, 1'b0, 128, -1);
        waitBusy(1'b1, "load_timeout");
        applyStimulus(8'hFF, 4'd8, 1'b0, 8'hFF, 8, 1'b0, 1'b0, 128, 16);
        checkOutput("dbuf_data_ready", data_ready, 0);
        checkOutput("dbuf_word_avail", word_avail, 1);
        checkOutput("dbuf_busy", busy, 1);
        waitWordEnd();
        waitWordEnd();

        // Abort after 3 bits of 0F with 3C waiting; 3C must survive and go out afterwards
        applyStimulus(8'h0F, 4'd8, 1'b0, 8'h07, 3, 1'b0, 1'b1, -1, -1);
        waitBusy(1'b1, "load_timeout");
        waitTicks(2);
        applyStimulus(8'h3C, 4'd8, 1'b0, 8'h3C, 8, 1'b0, 1'b0, 128, -1);
        @(negedge CLK);
        ser_en = 1'b0;
        @(negedge CLK);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ser_data", ser_data, 1);
        checkOutput("abort_word_avail", word_avail, 1);
        checkOutput("abort_data_ready", data_ready, 0);
        repeat (20) @(negedge CLK);
        ser_en = 1'b1;
        waitWordEnd();

        // DATA_VALID while full: 55 kept, AA dropped
        @(negedge CLK);
        ser_en = 1'b0;
        applyStimulus(8'h55, 4'd8, 1'b0, 8'h55, 8, 1'b0, 1'b0, 128, -1);
        DATA       = 8'hAA;
        DATA_VALID = 1'b1;
        repeat (5) @(negedge CLK);
        checkOutput("full_data_ready", data_ready, 0);
        checkOutput("full_word_avail", word_avail, 1);
        DATA_VALID = 1'b0;
        ser_en     = 1'b1;
        waitWordEnd();

        // Reset during the second bit of C3: idle values at once, no ser_done
        applyStimulus(8'hC3, 4'd8, 1'b0, 8'h03, 2, 1'b0, 1'b1, -1, -1);
        waitBusy(1'b1, "load_timeout");
        waitTicks(1);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("midrst_ser_data", ser_data, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_data_ready", data_ready, 1);
        checkOutput("midrst_word_avail", word_avail, 0);
        checkOutput("midrst_ser_done", ser_done, 0);
        @(negedge CLK);
        RST    = 1'b1;
        ser_en = 1'b0;

        repeat (40) @(negedge CLK);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
